// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   id_w()      : width of a channel index, never less than one bit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating picker: returns the first eligible channel found
// scanning upward from ptr and wrapping at N-1 -> 0. Tie ptr to zero for a
// plain lowest-index-wins priority encoder.
//   elig   : eligible channel vector
//   ptr    : scan start index (must be < N)
//   win    : one-hot winner, zero when nothing is eligible
//   win_id : winner index, zero when nothing is eligible
//   any    : at least one channel is eligible
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = id_w(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_id,
    output logic          any
);

    always_comb begin
        int j;
        win    = '0;
        win_id = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && elig[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                win_id = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Shares the single main-memory port among NUM_CH cache channels.
// A winner is registered out of IDLE, owns the port in GRANT until it
// signals done, drops its request, or the watchdog expires, then the port
// sits idle for exactly one RELEASE cycle before the next arbitration.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; eligible channels (req|wr) compete for next edge
//   GRANT   | owner drives mem_* through the muxes; hold counter runs
//   RELEASE | one dead cycle; late read data still steered to last owner
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req, wr, done     : per-channel read request, write strobe, finish pulse
//   addr, wdata       : packed per-channel address / write data
//   grant, grant_id   : one-hot owner and index of current/last owner
//   ch_valid          : mem_data_valid steered to the owner
//   mem_enable/wr/addr/wdata : memory port, muxed from the owner
//   mem_data_valid    : memory read data valid
//   busy              : GRANT or RELEASE
//   timeout_err       : sticky, set when the watchdog reclaims a grant
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          wr,
    input  logic [NUM_CH-1:0]          done,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    output logic [NUM_CH-1:0]          grant,
    output logic [id_w(NUM_CH)-1:0]    grant_id,
    output logic [NUM_CH-1:0]          ch_valid,
    output logic                       mem_enable,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_data_valid,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int ID_W  = id_w(NUM_CH);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic             WD_EN     = (MAX_HOLD > 0);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_CH - 1);

    arb_state_t        state, state_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic [ID_W-1:0]   grant_id_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic              timeout_nxt;
    logic              busy_nxt;

    logic [ID_W-1:0]   pick_ptr;
    logic [NUM_CH-1:0] pick_win;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;

    logic              own_act;
    logic              own_wr;
    logic              own_done;
    logic              wd_hit;

    // Fixed-priority mode reuses the same picker with the scan start pinned.
    assign pick_ptr = (RR_EN != 0) ? rr_ptr : '0;

    rr_pick #(
        .N  (NUM_CH),
        .IW (ID_W)
    ) u_pick (
        .elig   (req | wr),
        .ptr    (pick_ptr),
        .win    (pick_win),
        .win_id (pick_id),
        .any    (pick_any)
    );

    // grant is one-hot in GRANT, so masking selects only the owner's bits.
    assign own_act  = |((req | wr) & grant);
    assign own_wr   = |(wr & grant);
    assign own_done = |(done & grant);
    assign wd_hit   = WD_EN && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            rr_ptr      <= rr_ptr_nxt;
            hold_cnt    <= hold_cnt_nxt;
            timeout_err <= timeout_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = timeout_err;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt    = GRANT;
                    grant_nxt    = pick_win;
                    grant_id_nxt = pick_id;
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (own_done || !own_act || wd_hit) begin
                    state_nxt  = RELEASE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    // A done in the expiry cycle counts as a normal finish.
                    if (wd_hit && !own_done) begin
                        timeout_nxt = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = IDLE;
                grant_nxt    = '0;
                hold_cnt_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == GRANT) begin
            mem_enable = own_act;
            mem_wr     = own_wr;
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant[i]) begin
                    mem_addr  = addr[i*ADDR_W +: ADDR_W];
                    mem_wdata = wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Steered by grant_id rather than grant so RELEASE still routes late data.
    always_comb begin
        ch_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_valid[i] = mem_data_valid && (state != IDLE) && (grant_id == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

    logic        clk;
    logic        rst;
    logic [3:0]  req, wr, done;
    logic [63:0] addr, wdata;
    logic        mdv;

    int n_cmp = 0;
    int n_bad = 0;

    // dut_a: 4 ch round-robin, watchdog 8
    logic [3:0]  a_grant, a_chv;
    logic [1:0]  a_gid;
    logic        a_men, a_mwr, a_busy, a_terr;
    logic [15:0] a_maddr, a_mwd;
    // dut_b: 4 ch fixed priority, watchdog disabled
    logic [3:0]  b_grant, b_chv;
    logic [1:0]  b_gid;
    logic        b_men, b_mwr, b_busy, b_terr;
    logic [15:0] b_maddr, b_mwd;
    // dut_c: 2 ch defaults
    logic [1:0]  c_grant, c_chv;
    logic [0:0]  c_gid;
    logic        c_men, c_mwr, c_busy, c_terr;
    logic [15:0] c_maddr, c_mwd;

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .RR_EN(1), .MAX_HOLD(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .done(done), .addr(addr), .wdata(wdata),
        .grant(a_grant), .grant_id(a_gid), .ch_valid(a_chv), .mem_enable(a_men), .mem_wr(a_mwr),
        .mem_addr(a_maddr), .mem_wdata(a_mwd), .mem_data_valid(mdv), .busy(a_busy), .timeout_err(a_terr));

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .RR_EN(0), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .done(done), .addr(addr), .wdata(wdata),
        .grant(b_grant), .grant_id(b_gid), .ch_valid(b_chv), .mem_enable(b_men), .mem_wr(b_mwr),
        .mem_addr(b_maddr), .mem_wdata(b_mwd), .mem_data_valid(mdv), .busy(b_busy), .timeout_err(b_terr));

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .RR_EN(1), .MAX_HOLD(64)) dut_c (
        .clk(clk), .rst(rst), .req(req[1:0]), .wr(wr[1:0]), .done(done[1:0]), .addr(addr[31:0]),
        .wdata(wdata[31:0]), .grant(c_grant), .grant_id(c_gid), .ch_valid(c_chv), .mem_enable(c_men),
        .mem_wr(c_mwr), .mem_addr(c_maddr), .mem_wdata(c_mwd), .mem_data_valid(mdv), .busy(c_busy),
        .timeout_err(c_terr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, ex);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        wr    = '0;
        done  = '0;
        mdv   = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  gid;
        logic [3:0]  chv;
        logic        men;
        logic        mwr;
        logic [15:0] maddr;
        logic [15:0] mwd;
        logic        busy;
        logic        terr;
    } outs_t;

    int cfg_n  [3] = '{4, 4, 2};
    int cfg_rr [3] = '{1, 0, 1};
    int cfg_mh [3] = '{8, 0, 64};

    // phase: 0 no owner, 1 owned, 2 dead cycle after an owner
    int m_phase [3];
    int m_owner [3];
    int m_last  [3];
    int m_ptr   [3];
    int m_held  [3];
    bit m_terr  [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_phase[d] = 0; m_owner[d] = 0; m_last[d] = 0;
            m_ptr[d]   = 0; m_held[d]  = 0; m_terr[d] = 1'b0;
        end
    endfunction

    function automatic outs_t model_out(input int d);
        outs_t o;
        int    w;
        o      = '0;
        w      = m_owner[d];
        o.gid  = 2'(m_last[d]);
        o.busy = (m_phase[d] != 0);
        o.terr = m_terr[d];
        if (m_phase[d] == 1) begin
            o.grant = 4'(1 << w);
            o.men   = req[w] | wr[w];
            o.mwr   = wr[w];
            o.maddr = addr[w*16 +: 16];
            o.mwd   = wdata[w*16 +: 16];
        end
        if (m_phase[d] != 0 && mdv) o.chv = 4'(1 << m_last[d]);
        return o;
    endfunction

    function automatic void model_step(input int d);
        int  n, w, c;
        bit  fin, act, wd;
        n = cfg_n[d];
        w = -1;
        case (m_phase[d])
            0: begin
                for (int k = 0; k < n; k++) begin
                    c = (cfg_rr[d] != 0) ? (m_ptr[d] + k) % n : k;
                    if (w < 0 && (req[c] || wr[c])) w = c;
                end
                if (w >= 0) begin
                    m_phase[d] = 1; m_owner[d] = w; m_last[d] = w; m_held[d] = 0;
                end
            end
            1: begin
                w = m_owner[d];
                m_held[d] = m_held[d] + 1;
                fin = done[w];
                act = req[w] | wr[w];
                wd  = (cfg_mh[d] > 0) && (m_held[d] == cfg_mh[d]);
                if (fin || !act || wd) begin
                    if (wd && !fin) m_terr[d] = 1'b1;
                    m_ptr[d]   = (w + 1) % n;
                    m_phase[d] = 2;
                end
            end
            default: m_phase[d] = 0;
        endcase
    endfunction

    function automatic outs_t get_act(input int d);
        outs_t o;
        case (d)
            0:       o = {a_grant, a_gid, a_chv, a_men, a_mwr, a_maddr, a_mwd, a_busy, a_terr};
            1:       o = {b_grant, b_gid, b_chv, b_men, b_mwr, b_maddr, b_mwd, b_busy, b_terr};
            default: o = {2'b00, c_grant, 1'b0, c_gid, 2'b00, c_chv, c_men, c_mwr, c_maddr, c_mwd,
                          c_busy, c_terr};
        endcase
        return o;
    endfunction

    // ---------------- single-read vector table (dut_c) ----------------
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  done;
        logic        mdv;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic        e_men;
        logic [15:0] e_maddr;
        logic [1:0]  e_chv;
    } vec_t;

    vec_t vt [9];

    initial begin
        int ex;

        vt[0] = '{2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00};
        vt[1] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b00};
        vt[2] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b01};
        vt[3] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b00};
        vt[4] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b00};
        vt[5] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b01};
        vt[6] = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0040, 2'b00};
        vt[7] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b01};
        vt[8] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00};

        // reset values
        do_reset();
        #3;
        chk("rst_grant", a_grant, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_terr", a_terr, 0);
        chk("rst_men", a_men, 0);
        chk("rst_mwr", a_mwr, 0);
        chk("rst_maddr", a_maddr, 0);
        chk("rst_mwdata", a_mwd, 0);
        chk("rst_chv", a_chv, 0);

        // single read, table driven
        do_reset();
        addr[15:0] = 16'h0040;
        for (int k = 0; k < 9; k++) begin
            req  = {2'b00, vt[k].req};
            done = {2'b00, vt[k].done};
            mdv  = vt[k].mdv;
            #3;
            chk($sformatf("vec%0d_grant", k), c_grant, vt[k].e_grant);
            chk($sformatf("vec%0d_busy", k), c_busy, vt[k].e_busy);
            chk($sformatf("vec%0d_men", k), c_men, vt[k].e_men);
            chk($sformatf("vec%0d_maddr", k), c_maddr, vt[k].e_maddr);
            chk($sformatf("vec%0d_chv", k), c_chv, vt[k].e_chv);
            next_cycle();
        end

        // round-robin fairness, dut_a
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ex = k % 4;
            next_cycle(); #3;
            chk($sformatf("rr%0d_grant", k), a_grant, 64'(1 << ex));
            chk($sformatf("rr%0d_gid", k), a_gid, 64'(ex));
            next_cycle(); #3;
            chk($sformatf("rr%0d_hold", k), a_grant, 64'(1 << ex));
            next_cycle(); done = 4'(1 << ex); #3;
            chk($sformatf("rr%0d_done_cyc", k), a_grant, 64'(1 << ex));
            next_cycle(); done = '0; #3;
            chk($sformatf("rr%0d_rel_grant", k), a_grant, 0);
            chk($sformatf("rr%0d_rel_busy", k), a_busy, 1);
            next_cycle(); #3;
            chk($sformatf("rr%0d_idle_busy", k), a_busy, 0);
            chk($sformatf("rr%0d_idle_grant", k), a_grant, 0);
        end

        // fixed priority, dut_b
        do_reset();
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #3;
            chk($sformatf("fx%0d_grant", k), b_grant, 4'b0010);
            next_cycle(); done = 4'b0010; #3;
            chk($sformatf("fx%0d_hold", k), b_grant, 4'b0010);
            next_cycle(); done = '0; #3;
            chk($sformatf("fx%0d_rel", k), b_grant, 0);
            next_cycle(); #3;
            chk($sformatf("fx%0d_idle", k), b_busy, 0);
        end
        req = 4'b1000;
        next_cycle(); #3;
        chk("fx_ch3_grant", b_grant, 4'b1000);
        chk("fx_ch3_gid", b_gid, 3);

        // write pass-through, non-owner isolation, abandon, dut_a
        do_reset();
        req  = 4'b0010;
        addr = {16'h0, 16'h0, 16'h1000, 16'h1234};
        next_cycle(); #3;
        chk("wr_grant", a_grant, 4'b0010);
        chk("wr_rd_addr", a_maddr, 16'h1000);
        next_cycle();
        wr = 4'b0010; wdata[31:16] = 16'hBEEF; addr[15:0] = 16'h5555; wdata[15:0] = 16'hAAAA;
        #3;
        chk("wr_mem_wr", a_mwr, 1);
        chk("wr_mem_addr", a_maddr, 16'h1000);
        chk("wr_mem_wdata", a_mwd, 16'hBEEF);
        chk("wr_mem_en", a_men, 1);
        next_cycle();
        wr = '0; req = 4'b0011; addr[15:0] = 16'h7777;
        #3;
        chk("wr_off_mem_wr", a_mwr, 0);
        chk("wr_nonowner_addr", a_maddr, 16'h1000);
        chk("wr_nonowner_grant", a_grant, 4'b0010);
        next_cycle(); req = 4'b0001; #3;
        chk("abandon_men", a_men, 0);
        chk("abandon_grant", a_grant, 4'b0010);
        next_cycle(); #3;
        chk("abandon_rel_grant", a_grant, 0);
        chk("abandon_rel_busy", a_busy, 1);
        next_cycle(); #3;
        chk("abandon_idle_busy", a_busy, 0);
        next_cycle(); #3;
        chk("abandon_wrap_grant", a_grant, 4'b0001);

        // watchdog, dut_a expires; dut_b has it disabled
        do_reset();
        req = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            next_cycle(); #3;
            chk($sformatf("wd_g%0d_grant", k), a_grant, 4'b0001);
            chk($sformatf("wd_g%0d_terr", k), a_terr, 0);
        end
        next_cycle(); #3;
        chk("wd_rel_grant", a_grant, 0);
        chk("wd_rel_busy", a_busy, 1);
        chk("wd_rel_terr", a_terr, 1);
        next_cycle(); #3;
        chk("wd_idle_terr", a_terr, 1);
        chk("wd_idle_grant", a_grant, 0);
        next_cycle(); #3;
        chk("wd_next_grant", a_grant, 4'b0010);
        chk("wd_sticky_terr", a_terr, 1);
        chk("wd_off_grant", b_grant, 4'b0001);
        chk("wd_off_terr", b_terr, 0);
        // asynchronous reset mid-GRANT
        #1; rst = 1'b1; #1;
        chk("arst_grant", a_grant, 0);
        chk("arst_men", a_men, 0);
        chk("arst_terr", a_terr, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_gid", a_gid, 0);

        // done in the same cycle as watchdog expiry
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 7; k++) next_cycle();
        next_cycle(); done = 4'b0001; #3;
        chk("wd_done_g8_grant", a_grant, 4'b0001);
        next_cycle(); done = '0; #3;
        chk("wd_done_rel_grant", a_grant, 0);
        chk("wd_done_terr", a_terr, 0);

        // late valid during RELEASE, dropped in IDLE, dut_c
        do_reset();
        req = 4'b0010;
        next_cycle(); #3;
        chk("late_grant", c_grant, 2'b10);
        next_cycle(); done = 4'b0010; #3;
        next_cycle(); done = '0; req = '0; mdv = 1'b1; #3;
        chk("late_rel_chv", c_chv, 2'b10);
        chk("late_rel_gid", c_gid, 1);
        next_cycle(); #3;
        chk("late_idle_chv", c_chv, 2'b00);

        // randomized run against the reference model, all three DUTs
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            wr   = 4'($urandom_range(15)) & 4'($urandom_range(15)) & 4'($urandom_range(15));
            done = '0;
            if ($urandom_range(5) == 0) done[$urandom_range(3)] = 1'b1;
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            mdv   = 1'($urandom_range(1));
            #3;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rand_c%0d_dut%0d", cyc, d), get_act(d), model_out(d));
            end
            for (int d = 0; d < 3; d++) model_step(d);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
